shr_operand_fifo: RTL and testbench
===================================

// Module: shr_operand_fifo
// PURPOSE
//  Show-ahead FIFO holding (a, sh_amt) operand pairs for the SHR component directly downstream.
//  Decouples the operand-producing datapath stage from the shifter; the head entry drives SHR inputs directly.
//  Push/pop handshake with full/empty flags.
//  Sticky overflow/underflow error flags for the datapath controller.
// PARAMETERS
//  DATAWIDTH  2  width of a and sh_amt; matches the SHR DATAWIDTH
//  DEPTH      4  number of entries; power of two, >= 2
// PORTS
//  Clk        in   1            clock, rising edge
//  Rst        in   1            asynchronous reset, active-low
//  push       in   1            write {a_in, sh_amt_in} this cycle
//  a_in       in   DATAWIDTH    operand to shift
//  sh_amt_in  in   DATAWIDTH    shift amount
//  pop        in   1            consume head entry this cycle
//  a          out  DATAWIDTH    head operand; connects to SHR a
//  sh_amt     out  DATAWIDTH    head shift amount; connects to SHR sh_amt
//  empty      out  1            no valid entries
//  full       out  1            count == DEPTH
//  count      out  $clog2(DEPTH)+1  occupied entries
//  ovf        out  1            sticky: push rejected
//  unf        out  1            sticky: pop rejected
// BEHAVIOUR
//  - Reset (Rst=0, async): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, ovf=0, unf=0; a=0, sh_amt=0.
//    Storage contents are not reset.
//  - All state updates occur on the Clk rising edge.
//    empty and full are derived from registered count, so there are no combinational paths from push/pop.
//  - Output rule:
//    - a and sh_amt = mem[rd_ptr] when !empty, else 0. Mux from registered state only.
//    - Write-to-output latency: a push into an empty FIFO at edge N appears on a/sh_amt after edge N, i.e. one cycle later.
//  - Push is accepted if (!full) or (full and pop).
//    - Accepted push: mem[wr_ptr] <= {a_in, sh_amt_in}; wr_ptr increments modulo DEPTH.
//    - Rejected push (full and !pop): no state change except ovf <= 1.
//  - Pop is accepted if !empty.
//    - Accepted pop: rd_ptr increments modulo DEPTH.
//    - Rejected pop (empty): unf <= 1. A simultaneous push into an empty FIFO is still accepted, so count becomes 1.
//  - count update: +1 for an accepted push only, -1 for an accepted pop only, unchanged when both or neither are accepted.
//  - When full with push and pop in the same cycle:
//    - Head is retired and the new entry is written into the freed slot.
//    - count stays at DEPTH; ovf is not set.
//  - Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally.
//    full/empty are never inferred from pointer equality; count is authoritative.
//  - ovf and unf are sticky until reset.
//  - Reset asserted mid-operation discards all entries immediately (asynchronous).
//    The first edge after release behaves as from empty.
//  - No arithmetic on the data fields; widths pass through unchanged.
//    sh_amt is not range-checked; SHR semantics apply.
// STRUCTURE
//  - Shared header shr_defs.vh holds:
//    - default DATAWIDTH (2)
//    - default DEPTH (4)
//    - macro for count width: $clog2(DEPTH)+1
//  - One sub-module, fifo_ptr_ctr:
//    - holds the wr_ptr/rd_ptr/count registers
//    - implements the accept logic and full/empty derivation
//    - is instantiated once
//  - Storage is an array of DEPTH x (2*DATAWIDTH) registers in the top module, written at wr_ptr.
//  - Top-level connection: instance SHR takes a/sh_amt from this block; its d goes to the downstream REG.
// TESTING
//  1. Reset then idle:
//     empty=1, full=0, count=0, a=0, sh_amt=0, ovf=unf=0 held for 5 cycles.
//     Async check: drop Rst mid-cycle; outputs clear before the next edge.
//  2. Fill and drain, DATAWIDTH=2, DEPTH=4:
//     push (3,1),(2,0),(1,1),(3,2) -> full=1, count=4.
//     Pop x4 -> a/sh_amt sequence (3,1),(2,0),(1,1),(3,2), then empty=1 and outputs 0.
//  3. Overflow: at full, push (0,1) without pop -> count stays 4, ovf=1, head unchanged (3,1).
//     After draining, the 4 original entries emerge and (0,1) never appears.
//  4. Underflow: empty, pop with push (2,1) in the same cycle -> unf=1, count=1, a=2, sh_amt=1 next cycle.
//  5. Simultaneous push+pop at full:
//     - Stimulus: hold push+pop for 8 cycles with data k=0..7 (a=k[1:0], sh_amt=~k[1:0]).
//     - count stays 4 and ovf=0.
//     - Output order matches the push order across pointer wrap, checked against a scoreboard.
//  6. Reset mid-stream: with count=3, assert Rst for 1 cycle.
//     Then push (1,1) -> count=1, head (1,1); no stale entries appear on later pops.

Source files
------------

// File: rtl/shr_operand_fifo_pkg.sv
// Shared definitions for the SHR operand FIFO: default geometry and width helpers.
package shr_operand_fifo_pkg;

    // Default operand width; matches the downstream SHR DATAWIDTH.
    localparam int DATAWIDTH_DEF = 2;

    // Default number of FIFO entries (power of two, >= 2).
    localparam int DEPTH_DEF = 4;

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shr_operand_fifo_ptr_ctr.sv
// Pointer / occupancy controller for the SHR operand FIFO.
// Owns wr_ptr, rd_ptr and count. Decides whether push and pop are accepted.
// Derives registered full/empty from count (never from pointer equality).
// Holds the sticky overflow/underflow flags.
module fifo_ptr_ctr
    import shr_operand_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      push,
    input  logic                      pop,
    output logic [$clog2(DEPTH)-1:0]  wr_ptr,
    output logic [$clog2(DEPTH)-1:0]  rd_ptr_nxt,
    output logic                      push_acc,
    output logic                      head_empty_nxt,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      empty,
    output logic                      full,
    output logic                      ovf,
    output logic                      unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_r;
    logic             full_r;
    logic             ovf_r;
    logic             unf_r;

    logic             push_acc_s;
    logic             pop_acc_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;

    // Accept decisions and next-state values for pointers, count and sticky flags.
    always_comb begin
        push_acc_s   = 1'b0;
        pop_acc_s    = 1'b0;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;

        // Pop needs a valid head. A full FIFO always has one, so it frees a slot for push.
        pop_acc_s  = pop & ~empty_r;
        push_acc_s = push & (~full_r | pop);

        if (push_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_acc_s, pop_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        ovf_nxt_s = ovf_r | (push & ~push_acc_s);
        unf_nxt_s = unf_r | (pop & ~pop_acc_s);
    end

    // Pointer, occupancy and flag registers; reset discards all entries at once.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == CNT_W'(0));
            full_r   <= (count_nxt_s == CNT_W'(DEPTH));
            ovf_r    <= ovf_nxt_s;
            unf_r    <= unf_nxt_s;
        end
    end

    assign wr_ptr         = wr_ptr_r;
    assign rd_ptr_nxt     = rd_ptr_nxt_s;
    assign push_acc       = push_acc_s;
    assign head_empty_nxt = (count_nxt_s == CNT_W'(0));
    assign count          = count_r;
    assign empty          = empty_r;
    assign full           = full_r;
    assign ovf            = ovf_r;
    assign unf            = unf_r;

endmodule

// File: rtl/shr_operand_fifo.sv
// Show-ahead FIFO of (a, sh_amt) operand pairs feeding the SHR shifter.
// The head entry is held in a register so a/sh_amt come straight from flops.
// The head register is loaded with the entry that will be at rd_ptr after the edge.
// It shows zero whenever the FIFO will be empty.
module shr_operand_fifo
    import shr_operand_fifo_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic [DATAWIDTH-1:0]     a_in,
    input  logic [DATAWIDTH-1:0]     sh_amt_in,
    input  logic                     pop,
    output logic [DATAWIDTH-1:0]     a,
    output logic [DATAWIDTH-1:0]     sh_amt,
    output logic                     empty,
    output logic                     full,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 2 * DATAWIDTH;

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] head_nxt_s;
    logic [ENT_W-1:0] wr_data_s;

    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic             push_acc_s;
    logic             head_empty_nxt_s;

    assign wr_data_s = {a_in, sh_amt_in};

    fifo_ptr_ctr #(
        .DEPTH (DEPTH)
    ) u_ptr_ctr (
        .Clk            (Clk),
        .Rst            (Rst),
        .push           (push),
        .pop            (pop),
        .wr_ptr         (wr_ptr_s),
        .rd_ptr_nxt     (rd_ptr_nxt_s),
        .push_acc       (push_acc_s),
        .head_empty_nxt (head_empty_nxt_s),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .ovf            (ovf),
        .unf            (unf)
    );

    // Entry storage; contents are deliberately not reset, occupancy lives in count.
    always_ff @(posedge Clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_s] <= wr_data_s;
        end
    end

    // Next head value. Bypass the write data when the slot being written becomes the head.
    // That happens on a push into an empty FIFO, or on push+pop with a single entry.
    always_comb begin
        head_nxt_s = {ENT_W{1'b0}};
        if (head_empty_nxt_s) begin
            head_nxt_s = {ENT_W{1'b0}};
        end else if (push_acc_s && (wr_ptr_s == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Registered head entry driving the SHR operands.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            head_r <= {ENT_W{1'b0}};
        end else begin
            head_r <= head_nxt_s;
        end
    end

    assign a      = head_r[ENT_W-1:DATAWIDTH];
    assign sh_amt = head_r[DATAWIDTH-1:0];

endmodule

// File: tb/tb_shr_operand_fifo.sv
// Randomised and directed bench for shr_operand_fifo against a queue-based reference model.
module tb_shr_operand_fifo;

    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          Clk;
    logic          Rst;
    logic          push;
    logic [DW-1:0] a_in;
    logic [DW-1:0] sh_amt_in;
    logic          pop;
    logic [DW-1:0] a;
    logic [DW-1:0] sh_amt;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf;
    logic          unf;

    int total;
    int bad;

    // Reference model: list of stored entries as {a, sh_amt}, plus sticky flags.
    logic [2*DW-1:0] mq[$];
    logic            m_ovf;
    logic            m_unf;

    shr_operand_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (push),
        .a_in      (a_in),
        .sh_amt_in (sh_amt_in),
        .pop       (pop),
        .a         (a),
        .sh_amt    (sh_amt),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2*DW-1:0] hd;
        hd = (mq.size() > 0) ? mq[0] : 4'b0000;
        chk({tag, ".count"},  int'(count),  mq.size());
        chk({tag, ".empty"},  int'(empty),  int'(mq.size() == 0));
        chk({tag, ".full"},   int'(full),   int'(mq.size() == DEPTH));
        chk({tag, ".a"},      int'(a),      int'(hd[3:2]));
        chk({tag, ".sh_amt"}, int'(sh_amt), int'(hd[1:0]));
        chk({tag, ".ovf"},    int'(ovf),    int'(m_ovf));
        chk({tag, ".unf"},    int'(unf),    int'(m_unf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock: drive inputs, apply the FIFO rules to the model at the edge, check after it.
    task automatic cyc(input string tag, input logic p, input logic [DW-1:0] av,
                       input logic [DW-1:0] sv, input logic q);
        bit was_full;
        bit push_ok;
        bit pop_ok;
        push = p; a_in = av; sh_amt_in = sv; pop = q;
        @(posedge Clk);
        was_full = (mq.size() == DEPTH);
        pop_ok   = q && (mq.size() > 0);
        push_ok  = p && (!was_full || q);
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok)  m_unf = 1'b1;
        if (pop_ok)  void'(mq.pop_front());
        if (push_ok) mq.push_back({av, sv});
        #1;
        push = 1'b0; pop = 1'b0;
        check_all(tag);
    endtask

    // Drop reset mid-cycle, check the asynchronous clear, hold it across one edge, then release.
    task automatic async_reset(input string tag);
        #3 Rst = 1'b0;
        model_reset();
        #1 check_all({tag, ".async"});
        @(posedge Clk);
        #1 check_all({tag, ".held"});
        #2 Rst = 1'b1;
    endtask

    initial begin
        logic [2:0] kv;
        logic [DW-1:0] ka;
        total = 0; bad = 0;
        Rst = 1'b0; push = 1'b0; pop = 1'b0; a_in = '0; sh_amt_in = '0;
        model_reset();
        #12;
        check_all("rst");
        Rst = 1'b1;

        // 1. idle after reset
        for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 2'd0, 2'd0, 1'b0);
        cyc("pre_async", 1'b1, 2'd2, 2'd3, 1'b0);
        cyc("pre_async", 1'b1, 2'd1, 2'd0, 1'b0);
        async_reset("t1");

        // 2. fill and drain
        cyc("t2_push", 1'b1, 2'd3, 2'd1, 1'b0);
        chk("t2_first_a", int'(a), 3);
        chk("t2_first_sh", int'(sh_amt), 1);
        cyc("t2_push", 1'b1, 2'd2, 2'd0, 1'b0);
        cyc("t2_push", 1'b1, 2'd1, 2'd1, 1'b0);
        cyc("t2_push", 1'b1, 2'd3, 2'd2, 1'b0);
        chk("t2_full", int'(full), 1);
        chk("t2_count", int'(count), 4);
        for (int i = 0; i < 4; i++) cyc("t2_pop", 1'b0, 2'd0, 2'd0, 1'b1);
        chk("t2_empty", int'(empty), 1);

        // 3. overflow at full
        cyc("t3_push", 1'b1, 2'd3, 2'd1, 1'b0);
        cyc("t3_push", 1'b1, 2'd2, 2'd0, 1'b0);
        cyc("t3_push", 1'b1, 2'd1, 2'd1, 1'b0);
        cyc("t3_push", 1'b1, 2'd3, 2'd2, 1'b0);
        cyc("t3_ovf", 1'b1, 2'd0, 2'd1, 1'b0);
        chk("t3_ovf_set", int'(ovf), 1);
        chk("t3_head_a", int'(a), 3);
        chk("t3_head_sh", int'(sh_amt), 1);
        for (int i = 0; i < 5; i++) cyc("t3_drain", 1'b0, 2'd0, 2'd0, 1'b1);

        // 4. underflow with simultaneous push into empty
        async_reset("t4");
        cyc("t4_unf", 1'b1, 2'd2, 2'd1, 1'b1);
        chk("t4_unf_set", int'(unf), 1);
        chk("t4_count", int'(count), 1);
        chk("t4_a", int'(a), 2);
        chk("t4_sh", int'(sh_amt), 1);

        // 5. push+pop at full across pointer wrap
        for (int i = 0; i < 3; i++) cyc("t5_fill", 1'b1, DW'(i), DW'(i + 1), 1'b0);
        for (int k = 0; k < 8; k++) begin
            kv = 3'(k);
            ka = kv[1:0];
            cyc("t5_pp", 1'b1, ka, ~ka, 1'b1);
        end
        chk("t5_count", int'(count), 4);
        for (int i = 0; i < 4; i++) cyc("t5_drain", 1'b0, 2'd0, 2'd0, 1'b1);

        // 6. reset mid-stream with count=3
        for (int i = 0; i < 3; i++) cyc("t6_fill", 1'b1, 2'd2, DW'(i), 1'b0);
        async_reset("t6");
        cyc("t6_push", 1'b1, 2'd1, 2'd1, 1'b0);
        chk("t6_count", int'(count), 1);
        for (int i = 0; i < 3; i++) cyc("t6_pop", 1'b0, 2'd0, 2'd0, 1'b1);

        // Random traffic with occasional resets.
        async_reset("rnd0");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cyc("rnd", 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                    1'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
